// File: rtl/conv_frame_sequencer.sv
// Credit-metered frame sequencer in front of the 3x3 window generator.
// Optional macro ZERO_PAD_EN appends two zero lines after the source frame.
module conv_frame_sequencer #(
    parameter int IMG_W  = 512,
    parameter int IMG_H  = 512,
    parameter int NUM_LB = 4,
    parameter int DW     = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic [DW-1:0] i_pixel_data,
    input  logic          i_data_valid,
    output logic          o_data_ready,
    output logic [DW-1:0] o_pixel_data,
    output logic          o_data_valid,
    input  logic          i_intr,
    output logic          o_busy,
    output logic          o_frame_done,
    output logic          o_credit_err
);
    localparam int CW   = $clog2(NUM_LB + 1);
    localparam int COLW = $clog2(IMG_W);
    localparam int ROWW = $clog2(IMG_H + 3);

    localparam logic [CW-1:0]   CRED_MAX = CW'(NUM_LB);
    localparam logic [COLW-1:0] COL_LAST = COLW'(IMG_W - 1);
    localparam logic [ROWW-1:0] ROW_LAST = ROWW'(IMG_H - 1);
`ifdef ZERO_PAD_EN
    localparam logic [ROWW-1:0] PAD_LAST  = ROWW'(IMG_H + 1);
    localparam logic [ROWW-1:0] EXP_LINES = ROWW'(IMG_H);
`else
    localparam logic [ROWW-1:0] EXP_LINES = ROWW'(IMG_H - 2);
`endif

    typedef enum logic [2:0] {
        IDLE,
        STREAM,
`ifdef ZERO_PAD_EN
        PAD,
`endif
        DRAIN,
        DONE
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   credits;
    logic [COLW-1:0] col;
    logic [ROWW-1:0] row;
    logic [ROWW-1:0] lines_read;
    logic            beat;
    logic            line_end;
    logic            busy;

    assign line_end = beat && (col == COL_LAST);
    assign busy     = (state != IDLE);
    assign o_busy   = busy;

    always_comb begin
        state_nxt    = state;
        o_data_ready = 1'b0;
        o_data_valid = 1'b0;
        o_pixel_data = '0;
        o_frame_done = 1'b0;
        beat         = 1'b0;
        case (state)
            IDLE: begin
                if (i_start) state_nxt = STREAM;
            end
            STREAM: begin
                o_data_ready = (credits != '0);
                o_pixel_data = i_pixel_data;
                o_data_valid = i_data_valid && (credits != '0);
                beat         = o_data_valid;
                if (beat && (col == COL_LAST) && (row == ROW_LAST)) begin
`ifdef ZERO_PAD_EN
                    state_nxt = PAD;
`else
                    state_nxt = DRAIN;
`endif
                end
            end
`ifdef ZERO_PAD_EN
            PAD: begin
                // Zero lines obey the same credit gating as source lines.
                o_data_valid = (credits != '0);
                beat         = o_data_valid;
                if (beat && (col == COL_LAST) && (row == PAD_LAST)) state_nxt = DRAIN;
            end
`endif
            DRAIN: begin
                if (lines_read == EXP_LINES) state_nxt = DONE;
            end
            DONE: begin
                o_frame_done = 1'b1;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= IDLE;
            credits      <= CRED_MAX;
            col          <= '0;
            row          <= '0;
            lines_read   <= '0;
            o_credit_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if ((state == IDLE) && i_start) begin
                col        <= '0;
                row        <= '0;
                lines_read <= '0;
            end
            if (beat) begin
                col <= line_end ? '0 : col + 1'b1;
                if (line_end) row <= row + 1'b1;
            end
            if (i_intr && busy) lines_read <= lines_read + 1'b1;
            // A freed buffer and a filled buffer in one cycle cancel out.
            case ({line_end, i_intr})
                2'b10: credits <= credits - 1'b1;
                2'b01: begin
                    if (credits == CRED_MAX) o_credit_err <= 1'b1;
                    else                     credits      <= credits + 1'b1;
                end
                default: credits <= credits;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Directed bench for conv_frame_sequencer: vector table plus frame sequences
// driven against a simple window-generator read model.
module tb_conv_frame_sequencer;
    localparam int W   = 8;
    localparam int H   = 6;
    localparam int NLB = 4;
`ifdef ZERO_PAD_EN
    localparam int PAD_BEATS = 16;
    localparam int EXP       = 6;
`else
    localparam int PAD_BEATS = 0;
    localparam int EXP       = 4;
`endif

    logic       clk = 1'b0;
    logic       rst, start, dvalid, intr;
    logic [7:0] pix;
    logic       o_data_ready, o_data_valid, o_busy, o_frame_done, o_credit_err;
    logic [7:0] o_pixel_data;

    int n_cmp = 0;
    int n_bad = 0;

    conv_frame_sequencer #(.IMG_W(W), .IMG_H(H), .NUM_LB(NLB), .DW(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start),
        .i_pixel_data(pix), .i_data_valid(dvalid), .o_data_ready(o_data_ready),
        .o_pixel_data(o_pixel_data), .o_data_valid(o_data_valid), .i_intr(intr),
        .o_busy(o_busy), .o_frame_done(o_frame_done), .o_credit_err(o_credit_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, start, dv, intr;
        logic [7:0] pix;
        logic [4:0] ef;   // {ready, valid, busy, done, err}
        logic [7:0] ep;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pix_of(input int i);
        return 8'(i * 37 + 5);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; dvalid = 1'b0; intr = 1'b0; pix = 8'h00;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // mode 0: downstream withholds reads until ready has been low 5 cycles
    // mode 1: reads 1 cycle after each line, random source stalls
    // mode 2: reads coincide with line-completing beats
    // mode 3: random stalls, abort at row 3 col 5 (caller resets)
    task automatic run_frame(input int mode, input string tag);
        int src = 0, pad = 0, wr = 0, sent = 0, done_cnt = 0, at_done = -1;
        int ready_run = 0, low = 0, stall = 0, cyc = 0;
        bit seen_low = 0, en, pend = 0, hit = 0;
        logic r, v, b, d;
        logic [7:0] p;
        en = (mode != 0);
        b = 1'b1;
        @(negedge clk);
        start = 1'b1; dvalid = 1'b0; intr = 1'b0;
        while (cyc < 3000) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            dvalid = (mode == 1 || mode == 3) ? ($urandom_range(3) != 0) : 1'b1;
            pix = dvalid ? pix_of(src) : 8'($urandom);
            intr = pend;
            #1;
            if (mode == 2 && !intr && o_data_valid && (wr % W == W - 1) &&
                ((wr + 1) / W - sent >= 3) && sent < EXP) begin
                intr = 1'b1;
                #1;
            end
            r = o_data_ready; v = o_data_valid; p = o_pixel_data;
            d = o_frame_done; b = o_busy;
            if (intr) sent++;
            if (v) begin
                if (src < W * H) begin
                    check({tag, " pixel"}, 32'(p), 32'(pix_of(src)));
                    src++;
                end else begin
                    check({tag, " pad pixel"}, 32'(p), 32'h0);
                    check({tag, " pad ready"}, 32'(r), 32'h0);
                    pad++;
                end
                wr++;
            end
            if (src < W * H) begin
                if (r && !seen_low) ready_run++;
                if (!r) begin seen_low = 1; stall++; end
            end
            if (mode == 0 && seen_low && !en) begin
                low++;
                if (low >= 5) en = 1;
            end
            if (d) begin done_cnt++; at_done = sent; end
            if (mode == 3 && src == 3 * W + 5) begin hit = 1; break; end
            pend = (mode != 2) && en && (wr / W - sent >= 3) && (sent < EXP);
            if (done_cnt > 0 && !b) break;
        end
        if (mode == 3) begin
            check({tag, " reached row3 col5"}, 32'(hit), 32'h1);
        end else begin
            check({tag, " source beats"}, 32'(src), 32'(W * H));
            check({tag, " zero beats"}, 32'(pad), 32'(PAD_BEATS));
            check({tag, " done pulses"}, 32'(done_cnt), 32'h1);
            check({tag, " intr at done"}, 32'(at_done), 32'(EXP));
            check({tag, " idle after"}, 32'(b), 32'h0);
            if (mode == 0) begin
                check({tag, " initial ready run"}, 32'(ready_run), 32'd32);
                check({tag, " credit stall cycles"}, 32'(stall), 32'd6);
            end else begin
                check({tag, " stall cycles"}, 32'(stall), 32'h0);
            end
        end
    endtask

    vec_t tab[12];

    initial begin
        //        rst   start dv    intr  pix    {rdy,vld,busy,done,err} pix
        tab[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'hAA, 5'b00000, 8'h00};
        tab[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 5'b00000, 8'h00};
        tab[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 5'b00001, 8'h00};
        tab[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h55, 5'b00001, 8'h00};
        tab[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 5'b00001, 8'h00};
        tab[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 5'b00000, 8'h00};
        tab[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 5'b00000, 8'h00};
        tab[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h3C, 5'b11100, 8'h3C};
        tab[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h11, 5'b10100, 8'h11};
        tab[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h22, 5'b11100, 8'h22};
        tab[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h33, 5'b11100, 8'h33};
        tab[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h44, 5'b00000, 8'h00};

        rst = 1'b1; start = 1'b0; dvalid = 1'b0; intr = 1'b0; pix = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            rst = tab[i].rst; start = tab[i].start; dvalid = tab[i].dv;
            intr = tab[i].intr; pix = tab[i].pix;
            #1;
            check($sformatf("vector %0d", i),
                  32'({o_data_ready, o_data_valid, o_busy, o_frame_done, o_credit_err, o_pixel_data}),
                  32'({tab[i].ef, tab[i].ep}));
        end

        do_reset();
        run_frame(0, "credit-stall frame");
        do_reset();
        run_frame(2, "coincident frame");
        do_reset();
        run_frame(1, "stalled frame");
        do_reset();
        run_frame(3, "aborted frame");
        @(negedge clk);
        rst = 1'b1; dvalid = 1'b1; intr = 1'b0; pix = 8'hC3;
        @(negedge clk);
        rst = 1'b0; dvalid = 1'b1; pix = 8'h5A;
        #1;
        check("outputs after mid-frame reset",
              32'({o_data_ready, o_data_valid, o_busy, o_frame_done, o_credit_err, o_pixel_data}),
              32'h0);
        run_frame(1, "replay frame");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
